// File: rtl/mul_issue_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mul_issue_ctrl_if
// Brief    : EX-stage multiply handshake plus unsigned-multiplier start/done bus
// Revision : 1.0 - initial release
// ============================================================================
interface mul_issue_ctrl_if #(
    parameter int XLEN = 32
);
    logic                ex_valid;
    logic                ex_mul;
    logic [1:0]          ex_funct3;
    logic [XLEN-1:0]     ex_rs1;
    logic [XLEN-1:0]     ex_rs2;
    logic                flush;
    logic                stall;
    logic                res_valid;
    logic [XLEN-1:0]     res;
    logic                mul_start;
    logic [XLEN-1:0]     mul_a;
    logic [XLEN-1:0]     mul_b;
    logic                mul_done;
    logic [2*XLEN-1:0]   mul_product;
    logic                mul_err;

    modport slave (
        input  ex_valid, ex_mul, ex_funct3, ex_rs1, ex_rs2, flush,
        input  mul_done, mul_product,
        output stall, res_valid, res, mul_start, mul_a, mul_b, mul_err
    );

    modport master (
        output ex_valid, ex_mul, ex_funct3, ex_rs1, ex_rs2, flush,
        output mul_done, mul_product,
        input  stall, res_valid, res, mul_start, mul_a, mul_b, mul_err
    );
endinterface
`default_nettype wire

// File: rtl/mul_issue_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mul_issue_ctrl
// Brief    : RV32M multiply issue/stall/sign-fixup controller for an iterative
//            unsigned multiplier. Optional WAIT/DRAIN timeout: MUL_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mul_issue_ctrl #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    mul_issue_ctrl_if.slave    bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]          r_state;
    logic [2:0]          w_next;
    logic [1:0]          r_funct3;
    logic                r_neg;
    logic [XLEN-1:0]     r_a;
    logic [XLEN-1:0]     r_b;
    logic [XLEN-1:0]     r_res;

    logic                w_accept;
    logic                w_a_neg;
    logic                w_b_neg;
    logic                w_wait;
    logic                w_drain;
    logic                w_tmo;
    logic                w_tmo_wait;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_sel;

    assign w_accept = (r_state == S_IDLE) & bus.ex_valid & bus.ex_mul & ~bus.flush;
    assign w_wait   = (r_state == S_WAIT);
    assign w_drain  = (r_state == S_DRAIN);

    // Only MULH treats rs2 as signed; MULH and MULHSU treat rs1 as signed.
    assign w_a_neg = bus.ex_rs1[XLEN-1] & ((bus.ex_funct3 == 2'b01) | (bus.ex_funct3 == 2'b10));
    assign w_b_neg = bus.ex_rs2[XLEN-1] & (bus.ex_funct3 == 2'b01);

    assign w_prod = r_neg ? (-bus.mul_product) : bus.mul_product;
    assign w_sel  = (r_funct3 == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

`ifdef MUL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;

    assign w_tmo = (w_wait | w_drain) & (r_cnt == CW'(TIMEOUT - 1)) & ~bus.mul_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (((w_next == S_WAIT) || (w_next == S_DRAIN)) && (w_next != r_state)) begin
            r_cnt <= '0;
        end else if (w_wait | w_drain) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end
`else
    // Without the counter the multiplier is trusted to always answer.
    assign w_tmo = 1'b0 & (TIMEOUT > 0);
`endif

    assign w_tmo_wait = w_wait & w_tmo;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_ISSUE;
            S_ISSUE: w_next = bus.flush ? S_DRAIN : S_WAIT;
            S_WAIT: begin
                if (bus.mul_done)
                    w_next = bus.flush ? S_IDLE : S_DONE;
                else if (w_tmo)
                    w_next = S_IDLE;
                else if (bus.flush)
                    w_next = S_DRAIN;
            end
            S_DONE:  w_next = S_IDLE;
            S_DRAIN: if (bus.mul_done | w_tmo) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_funct3 <= 2'b00;
            r_neg    <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_funct3 <= bus.ex_funct3;
                r_a      <= w_a_neg ? (-bus.ex_rs1) : bus.ex_rs1;
                r_b      <= w_b_neg ? (-bus.ex_rs2) : bus.ex_rs2;
                r_neg    <= w_a_neg ^ w_b_neg;
            end
            if (w_wait) begin
                if (bus.mul_done & ~bus.flush)
                    r_res <= w_sel;
                else if (w_tmo)
                    r_res <= '0;
            end
        end
    end

    assign bus.stall     = w_accept | (r_state == S_ISSUE) | w_wait | w_drain;
    assign bus.mul_start = (r_state == S_ISSUE);
    assign bus.mul_a     = r_a;
    assign bus.mul_b     = r_b;
    assign bus.res_valid = ((r_state == S_DONE) | w_tmo_wait) & ~bus.flush;
    assign bus.res       = w_tmo_wait ? '0 : r_res;
    assign bus.mul_err   = w_tmo;

endmodule
`default_nettype wire

// File: tb/tb_mul_issue_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mul_issue_ctrl
// Brief    : Scoreboard bench for mul_issue_ctrl with an iterative multiplier
//            model; timeout case compiled in with MUL_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_issue_ctrl;
    localparam int XLEN    = 32;
    localparam int TIMEOUT = 64;

    typedef struct { logic [31:0] res; int cyc; logic err; } exp_t;
    typedef struct { logic [31:0] a; logic [31:0] b; } mag_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   lat_next = 1;
    bit   model_hang = 1'b0;
    bit   model_busy = 1'b0;
    exp_t sb_q[$];
    mag_t mag_q[$];

    mul_issue_ctrl_if #(.XLEN(XLEN)) bus();

    mul_issue_ctrl #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic check_zero(string tag);
        check({tag, "_stall"},     64'(bus.stall),     64'd0);
        check({tag, "_res_valid"}, 64'(bus.res_valid), 64'd0);
        check({tag, "_res"},       64'(bus.res),       64'd0);
        check({tag, "_mul_start"}, 64'(bus.mul_start), 64'd0);
        check({tag, "_mul_a"},     64'(bus.mul_a),     64'd0);
        check({tag, "_mul_b"},     64'(bus.mul_b),     64'd0);
        check({tag, "_mul_err"},   64'(bus.mul_err),   64'd0);
    endtask

    // Architectural RV32M result computed with wide plain arithmetic.
    function automatic logic [31:0] ref_mul(logic [1:0] f3, logic [31:0] a, logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0] ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f3)
            2'b01:   p = sa * sb;
            2'b10:   p = sa * $signed(ub);
            default: p = ua * ub;
        endcase
        return (f3 == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom();
        endcase
    endfunction

    // Iterative multiplier model: done arrives lat_next cycles after start.
    initial begin
        bus.mul_done    = 1'b0;
        bus.mul_product = '0;
        forever begin
            @(negedge clk);
            if (bus.mul_start === 1'b1) begin
                mag_t m;
                logic [31:0] a0, b0;
                a0 = bus.mul_a;
                b0 = bus.mul_b;
                if (mag_q.size() == 0) begin
                    check("start_without_op", 64'(bus.mul_start), 64'd0);
                end else begin
                    m = mag_q.pop_front();
                    check("mul_a", 64'(bus.mul_a), 64'(m.a));
                    check("mul_b", 64'(bus.mul_b), 64'(m.b));
                end
                if (!model_hang) begin
                    model_busy = 1'b1;
                    repeat (lat_next) @(negedge clk);
                    if (bus.stall === 1'b1)
                        check("mul_ab_hold", {bus.mul_a, bus.mul_b}, {a0, b0});
                    bus.mul_done    = 1'b1;
                    bus.mul_product = {32'd0, a0} * {32'd0, b0};
                    @(negedge clk);
                    bus.mul_done    = 1'b0;
                    bus.mul_product = '0;
                    model_busy = 1'b0;
                end
            end
        end
    end

    // Result monitor: pops the scoreboard whenever res_valid is seen.
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            #2;
            if (bus.res_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("res_valid_unexpected", 64'(bus.res_valid), 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("res",       64'(bus.res),     64'(e.res));
                    check("res_cycle", 64'(cyc),         64'(e.cyc));
                    check("res_err",   64'(bus.mul_err), 64'(e.err));
                end
            end else if (bus.mul_err === 1'b1) begin
                check("mul_err_unexpected", 64'(bus.mul_err), 64'd0);
            end
        end
    end

    // fk: cycle offset of a one-cycle flush (0 = none); rk: offset of an async reset.
    task automatic do_op(logic [1:0] f3, logic [31:0] a, logic [31:0] b,
                         int lat, int fk, int rk, bit hang);
        mag_t m;
        exp_t e;
        int   a0;
        int   k;
        lat_next   = lat;
        model_hang = hang;
        bus.ex_valid  = 1'b1;
        bus.ex_mul    = 1'b1;
        bus.ex_funct3 = f3;
        bus.ex_rs1    = a;
        bus.ex_rs2    = b;
        a0  = cyc;
        m.a = ((f3 == 2'b01 || f3 == 2'b10) && a[31]) ? -a : a;
        m.b = ((f3 == 2'b01) && b[31]) ? -b : b;
        mag_q.push_back(m);
        if (hang) begin
            e.res = 32'd0; e.cyc = a0 + TIMEOUT + 1; e.err = 1'b1;
            sb_q.push_back(e);
        end else if (rk == 0 && (fk == 0 || fk > lat + 2)) begin
            e.res = ref_mul(f3, a, b); e.cyc = a0 + lat + 2; e.err = 1'b0;
            sb_q.push_back(e);
        end
        for (k = 0; k < 300; k++) begin
            if (k == 1) begin
                bus.ex_valid = 1'b0;
                bus.ex_mul   = 1'b0;
            end
            bus.flush = (fk != 0 && k == fk);
            if (rk != 0 && k == rk) begin
                #3 rst = 1'b0;
                #1 check_zero("async_rst");
                @(negedge clk);
                rst = 1'b1;
                for (int w = 0; w < 200 && model_busy; w++) @(negedge clk);
                @(negedge clk);
                return;
            end
            #1;
            if (bus.stall !== 1'b1) break;
            @(negedge clk);
        end
        check("stall_cycles", 64'(k), hang ? 64'(TIMEOUT + 2) : 64'(lat + 2));
        @(negedge clk);
        bus.flush = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.ex_valid    = 1'b0;
        bus.ex_mul      = 1'b0;
        bus.ex_funct3   = 2'b00;
        bus.ex_rs1      = '0;
        bus.ex_rs2      = '0;
        bus.flush       = 1'b0;
        repeat (2) @(negedge clk);
        #1 check_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        do_op(2'b00, 32'd7, 32'd6, 32, 0, 0, 1'b0);
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 0, 0, 1'b0);
        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 0, 0, 1'b0);
        do_op(2'b10, 32'hFFFF_FFFF, 32'd2, 3, 0, 0, 1'b0);
        do_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 0, 1'b0);
        do_op(2'b00, 32'h0000_1234, 32'h0000_5678, 20, 7, 0, 1'b0);
        do_op(2'b00, 32'd3, 32'd3, 4, 0, 0, 1'b0);
        do_op(2'b01, 32'h8000_0000, 32'd5, 6, 1, 0, 1'b0);
        do_op(2'b01, 32'h8000_0000, 32'd5, 6, 7, 0, 1'b0);
        do_op(2'b01, 32'h8000_0000, 32'd5, 6, 8, 0, 1'b0);
        do_op(2'b00, 32'd5, 32'd5, 20, 0, 7, 1'b0);
        do_op(2'b00, 32'd11, 32'd13, 2, 0, 0, 1'b0);
`ifdef MUL_TIMEOUT_EN
        do_op(2'b11, 32'd9, 32'd9, 1, 0, 0, 1'b1);
        do_op(2'b00, 32'd4, 32'd4, 2, 0, 0, 1'b0);
`endif
        for (int i = 0; i < 40; i++) begin
            int lat, fk;
            lat = $urandom_range(1, 10);
            fk  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lat + 2) : 0;
            do_op(2'($urandom_range(0, 3)), pick(), pick(), lat, fk, 0, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_left", 64'(sb_q.size()), 64'd0);
        check("start_missing",   64'(mag_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
